// File: rtl/pivot_cyc_pkg.sv
// Shared constants, depth helper and FSM encoding for the pivot-cycle store.
package pivot_cyc_pkg;

  localparam int READ_LAT = 3;

  typedef enum logic {
    PC_INIT,
    PC_READY
  } pc_state_t;

  // One word per pivot row group per elimination phase.
  function automatic int pc_depth(input int n, input int l);
    return $clog2(l) * (l / n);
  endfunction

endpackage

// File: rtl/pivot_cyc_store_if.sv
// Save/restore port between the pivot-cycle initiator and its storage responder.
interface pivot_cyc_store_if #(
  parameter int N  = 64,
  parameter int AW = 120
);

  logic [N-1:0]  mem_data;
  logic [N-1:0]  mem_q;
  logic [AW-1:0] mem_addr;
  logic          mem_wren;
  logic          mem_rden;
  logic          init_req;
  logic          err_clr;
  logic          ready;
  logic          access_err;

  modport master (
    output mem_data, mem_addr, mem_wren, mem_rden, init_req, err_clr,
    input  mem_q, ready, access_err
  );

  modport slave (
    input  mem_data, mem_addr, mem_wren, mem_rden, init_req, err_clr,
    output mem_q, ready, access_err
  );

endinterface

// File: rtl/pivot_cyc_ram.sv
// Simple dual-port DEPTH x W array: registered read address, registered read data, no reset.
module pivot_cyc_ram #(
  parameter int W     = 64,
  parameter int DEPTH = 120,
  parameter int DW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [DW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [DW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0]  mem [DEPTH];
  logic [DW-1:0] raddr_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) raddr_q <= raddr;
    rdata <= mem[raddr_q];
  end

endmodule

// File: rtl/pivot_cyc_store.sv
// Storage responder for the pivot-cycle save/restore port: self-zeroing array,
// fixed 3-edge read latency, sticky illegal-access flag.
module pivot_cyc_store
  import pivot_cyc_pkg::*;
#(
  parameter int N = 64,
  parameter int L = 768
) (
  input logic clk,
  input logic rst_n,
  pivot_cyc_store_if.slave bus
);

  localparam int D  = pc_depth(N, L);
  localparam int AW = $clog2(L) * L / N;
  localparam int DW = $clog2(D);

  pc_state_t     state, state_next;
  logic [DW-1:0] ptr, ptr_next;

  logic          in_range, strobe, illegal, err_hit, wr_ok;
  logic          ram_we;
  logic [DW-1:0] ram_waddr;
  logic [N-1:0]  ram_wdata, ram_rdata;

  logic          s1_valid, s1_zero;
  logic [DW-1:0] s1_addr;
  logic          s2a_valid, s2a_zero, s2b_valid, s2b_zero;
  logic [N-1:0]  mem_q_r;
  logic          access_err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PC_INIT;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      PC_INIT: begin
        ptr_next = ptr + DW'(1);
        if (ptr == DW'(D - 1)) state_next = PC_READY;
      end
      PC_READY: begin
        if (bus.init_req) begin
          state_next = PC_INIT;
          ptr_next   = '0;
        end
      end
      default: state_next = PC_INIT;
    endcase
  end

  // Any strobe while zeroing or outside the bank is illegal; the high address
  // bits take part in the compare so aliases of legal words are caught too.
  assign in_range = (bus.mem_addr < AW'(D));
  assign strobe   = bus.mem_wren | bus.mem_rden;
  assign illegal  = (state == PC_INIT) | ~in_range;
  assign err_hit  = strobe & illegal;
  assign wr_ok    = bus.mem_wren & ~illegal;

  assign ram_we    = (state == PC_INIT) | wr_ok;
  assign ram_waddr = (state == PC_INIT) ? ptr : bus.mem_addr[DW-1:0];
  assign ram_wdata = (state == PC_INIT) ? '0 : bus.mem_data;

  pivot_cyc_ram #(
    .W     (N),
    .DEPTH (D),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (s1_valid),
    .raddr (s1_addr),
    .rdata (ram_rdata)
  );

  // Illegal reads still walk the pipeline so they return zero at normal latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_zero      <= 1'b0;
      s1_addr      <= '0;
      s2a_valid    <= 1'b0;
      s2a_zero     <= 1'b0;
      s2b_valid    <= 1'b0;
      s2b_zero     <= 1'b0;
      mem_q_r      <= '0;
      access_err_r <= 1'b0;
    end else begin
      s1_valid  <= bus.mem_rden;
      s1_zero   <= illegal;
      s1_addr   <= illegal ? '0 : bus.mem_addr[DW-1:0];
      s2a_valid <= s1_valid;
      s2a_zero  <= s1_zero;
      s2b_valid <= s2a_valid;
      s2b_zero  <= s2a_zero;
      if (s2b_valid) mem_q_r <= s2b_zero ? '0 : ram_rdata;
      if (err_hit)           access_err_r <= 1'b1;
      else if (bus.err_clr)  access_err_r <= 1'b0;
    end
  end

  assign bus.mem_q      = mem_q_r;
  assign bus.ready      = (state == PC_READY);
  assign bus.access_err = access_err_r;

endmodule

// File: tb/tb_pivot_cyc_store.sv
// Directed self-checking bench for pivot_cyc_store at N=64, L=768 (120 words).
module tb_pivot_cyc_store;
  import pivot_cyc_pkg::*;

  localparam int N  = 64;
  localparam int L  = 768;
  localparam int D  = 120;
  localparam int AW = 120;
  localparam logic [N-1:0] A5   = {(N/8){8'hA5}};
  localparam logic [N-1:0] ONES = {N{1'b1}};

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [N-1:0]  exp_mem [D];
  logic [AW-1:0] big;

  pivot_cyc_store_if #(.N(N), .AW(AW)) bus ();

  pivot_cyc_store #(.N(N), .L(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [N-1:0] pat(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {(N/8){b}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic [AW-1:0] addr, input logic [N-1:0] data);
    bus.mem_wren = wr;
    bus.mem_rden = rd;
    bus.mem_addr = addr;
    bus.mem_data = data;
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] observed,
                             input logic [N-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Back-to-back read of the whole bank, one word checked per cycle.
  task automatic readAll(input string tag);
    for (int c = 0; c < D + READ_LAT; c++) begin
      applyStimulus(1'b0, c < D, AW'(c), '0);
      step();
      if (c >= READ_LAT)
        checkOutput($sformatf("%s_%0d", tag, c - READ_LAT), bus.mem_q, exp_mem[c - READ_LAT]);
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  // Called just after rst_n rises between edges: ready must appear on edge 120 exactly.
  task automatic waitReady(input string tag);
    int rdy_cnt;
    int q_cnt;
    rdy_cnt = 0;
    q_cnt   = 0;
    for (int i = 1; i < D; i++) begin
      step();
      if (bus.ready) rdy_cnt++;
      if (bus.mem_q !== '0) q_cnt++;
    end
    checkOutput({tag, "_ready_low"}, N'(rdy_cnt), '0);
    checkOutput({tag, "_q_quiet"}, N'(q_cnt), '0);
    step();
    checkOutput({tag, "_ready_rise"}, N'(bus.ready), N'(1));
  endtask

  initial begin
    int rdy_cnt;
    rst_n        = 1'b0;
    bus.init_req = 1'b0;
    bus.err_clr  = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < D; i++) exp_mem[i] = '0;

    step();
    step();
    checkOutput("rst_mem_q", bus.mem_q, '0);
    checkOutput("rst_ready", N'(bus.ready), '0);
    checkOutput("rst_err", N'(bus.access_err), '0);

    rst_n = 1'b1;
    waitReady("release");
    readAll("zero");
    checkOutput("err_after_reads", N'(bus.access_err), '0);

    $display("[TB] write/read burst 30..39");
    for (int a = 30; a < 40; a++) begin
      applyStimulus(1'b1, 1'b0, AW'(a), pat(a));
      exp_mem[a] = pat(a);
      step();
    end
    for (int c = 0; c < 13; c++) begin
      applyStimulus(1'b0, c < 10, AW'(30 + c), '0);
      step();
      if (c == 2) checkOutput("burst_latency", bus.mem_q, '0);
      if (c >= 3) checkOutput($sformatf("burst_%0d", 27 + c), bus.mem_q, pat(27 + c));
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    step();
    checkOutput("burst_hold", bus.mem_q, pat(39));

    $display("[TB] same-edge read and write");
    applyStimulus(1'b1, 1'b1, AW'(5), A5);
    exp_mem[5] = A5;
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    step();
    checkOutput("rw_latency", bus.mem_q, pat(39));
    step();
    checkOutput("rw_same_edge", bus.mem_q, A5);

    $display("[TB] out-of-range accesses");
    checkOutput("err_pre", N'(bus.access_err), '0);
    applyStimulus(1'b0, 1'b1, AW'(120), '0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("oor_rd_err", N'(bus.access_err), N'(1));
    step();
    step();
    checkOutput("oor_rd_latency", bus.mem_q, A5);
    step();
    checkOutput("oor_rd_q", bus.mem_q, '0);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    checkOutput("err_clr", N'(bus.access_err), '0);

    bus.err_clr = 1'b1;
    applyStimulus(1'b0, 1'b1, AW'(200), '0);
    step();
    bus.err_clr = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("clr_vs_err", N'(bus.access_err), N'(1));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    checkOutput("err_clr2", N'(bus.access_err), '0);

    // Writes whose low address bits alias legal words 5 and 7 must be dropped.
    applyStimulus(1'b1, 1'b0, AW'(120), ONES);
    step();
    checkOutput("oor_wr_err", N'(bus.access_err), N'(1));
    applyStimulus(1'b1, 1'b0, AW'(133), ONES);
    step();
    big = '0;
    big[100] = 1'b1;
    big[6:0] = 7'd7;
    applyStimulus(1'b1, 1'b0, big, ONES);
    step();
    big[6:0] = 7'd30;
    applyStimulus(1'b0, 1'b1, AW'(31), '0);
    step();
    applyStimulus(1'b0, 1'b1, big, '0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    step();
    checkOutput("pre_alias_rd", bus.mem_q, pat(31));
    step();
    checkOutput("alias_rd_q", bus.mem_q, '0);
    checkOutput("alias_err", N'(bus.access_err), N'(1));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    readAll("after_oor");

    $display("[TB] re-init");
    bus.init_req = 1'b1;
    step();
    bus.init_req = 1'b0;
    checkOutput("reinit_ready_fall", N'(bus.ready), '0);
    rdy_cnt = 0;
    for (int i = 1; i < D; i++) begin
      bus.init_req = (i == 50);
      if (i == 60) applyStimulus(1'b1, 1'b0, AW'(3), 64'hDEAD_BEEF_DEAD_BEEF);
      else         applyStimulus(1'b0, 1'b0, '0, '0);
      step();
      if (bus.ready) rdy_cnt++;
      if (i == 60) checkOutput("init_wr_err", N'(bus.access_err), N'(1));
    end
    bus.init_req = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("reinit_ready_low", N'(rdy_cnt), '0);
    step();
    checkOutput("reinit_ready_rise", N'(bus.ready), N'(1));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    for (int i = 0; i < D; i++) exp_mem[i] = '0;
    readAll("reinit");

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 1'b0, AW'(10), ONES);
    step();
    applyStimulus(1'b0, 1'b1, AW'(10), '0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    step();
    step();
    checkOutput("pre_rst_q", bus.mem_q, ONES);
    applyStimulus(1'b0, 1'b1, AW'(10), '0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_q_now", bus.mem_q, '0);
    checkOutput("midrst_ready", N'(bus.ready), '0);
    step();
    step();
    checkOutput("midrst_q_held", bus.mem_q, '0);
    rst_n = 1'b1;
    waitReady("midrst");
    checkOutput("midrst_q_final", bus.mem_q, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
